// File: rtl/rvb_bitcnt_iter.sv
// Iterative bit counter (CLZ/CTZ/PCNT, W variants) with single-cycle SEXT.B/SEXT.H.
// Counts CHUNK bits per cycle; CLZ/CTZ stop early at the first chunk that is not all ones.
module rvb_bitcnt_iter #(
  parameter int XLEN  = 64,
  parameter int CHUNK = 16
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            din_valid,
  output logic            din_ready,
  input  logic [XLEN-1:0] din_rs1,
  input  logic            din_insn3,
  input  logic            din_insn20,
  input  logic            din_insn21,
  input  logic            din_insn22,
  output logic            dout_valid,
  input  logic            dout_ready,
  output logic [XLEN-1:0] dout_rd
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   work_q;
  logic [XLEN-1:0]   rd_q;
  logic [6:0]        acc_q;
  logic [2:0]        idx_q;
  logic [2:0]        last_q;
  logic              early_q;

  logic [2:0]        op;
  logic              is_cnt, is_clz, is_ctzlike, wmode;
  logic [31:0]       rev32;
  logic [XLEN-1:0]   revx, base, work_init, sext_val;
  logic [XLEN-1:0]   shifted;
  logic [CHUNK-1:0]  chunk;
  logic [6:0]        pc, acc_sum;
  logic              run_last;

  assign op         = {din_insn22, din_insn21, din_insn20};
  assign is_cnt     = (op == 3'b000) || (op == 3'b001) || (op == 3'b010);
  assign is_clz     = (op == 3'b000);
  assign is_ctzlike = (op[2:1] == 2'b00);
  assign wmode      = (XLEN == 32) || din_insn3;

  // Operand preparation: CLZ becomes CTZ of the reversed word, CTZ becomes a popcount of (v-1)&~v.
  always_comb begin
    rev32 = '0;
    revx  = '0;
    for (int i = 0; i < 32; i++)   rev32[i] = din_rs1[31-i];
    for (int i = 0; i < XLEN; i++) revx[i]  = din_rs1[XLEN-1-i];
    if (is_clz) base = wmode ? XLEN'(rev32) : revx;
    else        base = wmode ? XLEN'(din_rs1[31:0]) : din_rs1;
    work_init = is_ctzlike ? ((base - XLEN'(1)) & ~base) : base;
  end

  always_comb begin
    case (op)
      3'b100:  sext_val = {{(XLEN-8){din_rs1[7]}}, din_rs1[7:0]};
      3'b101:  sext_val = {{(XLEN-16){din_rs1[15]}}, din_rs1[15:0]};
      default: sext_val = '0;
    endcase
  end

  always_comb begin
    shifted = work_q >> (CHUNK * int'(idx_q));
    chunk   = shifted[CHUNK-1:0];
    pc      = '0;
    for (int i = 0; i < CHUNK; i++) pc = pc + {6'd0, chunk[i]};
    acc_sum  = acc_q + pc;
    run_last = (idx_q == last_q) || (early_q && !(&chunk));
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (din_valid) state_d = is_cnt ? S_RUN : S_DONE;
      S_RUN:   if (run_last) state_d = S_DONE;
      S_DONE:  if (dout_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    din_ready  = (state_q == S_IDLE) && !reset;
    dout_valid = (state_q == S_DONE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      work_q  <= '0;
      rd_q    <= '0;
      acc_q   <= '0;
      idx_q   <= '0;
      last_q  <= '0;
      early_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (din_valid) begin
            if (is_cnt) begin
              work_q  <= work_init;
              acc_q   <= '0;
              idx_q   <= '0;
              last_q  <= wmode ? 3'(32/CHUNK - 1) : 3'(XLEN/CHUNK - 1);
              early_q <= is_ctzlike;
            end else begin
              rd_q <= sext_val;
            end
          end
        end
        S_RUN: begin
          acc_q <= acc_sum;
          idx_q <= idx_q + 3'd1;
          if (run_last) rd_q <= XLEN'(acc_sum);
        end
        default: ;
      endcase
    end
  end

  assign dout_rd = rd_q;

endmodule

// File: doc/rvb_bitcnt_iter.md
RVB_BITCNT_ITER -- requirements
Module: rvb_bitcnt_iter

Interface
REQ-001 SHALL have parameter XLEN, default 64: datapath width; only 32 and 64 are legal.
REQ-002 SHALL have parameter CHUNK, default 16: bits counted per cycle; legal values are 8, 16 and 32, and CHUNK must divide 32.
REQ-003 SHALL have port clock, input, 1: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port din_valid, input, 1: request valid.
REQ-006 SHALL have port din_ready, output, 1: block accepts a request.
REQ-007 SHALL have port din_rs1, input, XLEN: operand.
REQ-008 SHALL have ports din_insn3, din_insn20, din_insn21 and din_insn22, each input, 1: operation select bits.
REQ-009 SHALL have port dout_valid, output, 1: result valid.
REQ-010 SHALL have port dout_ready, input, 1: consumer accepts the result.
REQ-011 SHALL have port dout_rd, output, XLEN: result, registered.

Function
REQ-012 SHALL decode {insn22,insn21,insn20} as follows: 000 CLZ, 001 CTZ, 010 PCNT, 100 SEXT.B, 101 SEXT.H; the codes 011, 110 and 111 SHALL return 0 via the single-cycle path.
REQ-013 SHALL use W mode when XLEN==32 or insn3=1; SEXT ignores insn3.
REQ-014 SHALL implement a three-state FSM: IDLE, RUN, DONE; reset state is IDLE.
REQ-015 SHALL drive din_ready=1 only in IDLE and dout_valid=1 only in DONE; both are pure decodes of the state.
REQ-016 SHALL accept a request on (IDLE && din_valid); rs1 is sampled only at that edge.
REQ-017 On accepting a count op, SHALL compute a work vector from rs1:
- CLZ: bit-reverse first (W mode reverses bits 31:0 into bits 31:0).
- W mode: zero bits XLEN-1:32.
- CLZ/CTZ: then apply (v-1)&~v.
- Latch the result, clear the accumulator and the chunk index, and go to RUN.
REQ-018 In RUN, each cycle SHALL add popcount(work[idx*CHUNK +: CHUNK]) to the accumulator and increment idx.
REQ-019 SHALL set the chunk limit N to 32/CHUNK in W mode and XLEN/CHUNK otherwise; chunks at or above N are never counted.
REQ-020 SHALL leave RUN after the cycle processing chunk N-1.
REQ-021 For CLZ/CTZ only, SHALL also leave RUN after the first chunk that is not all ones (early termination); PCNT always runs N cycles.
REQ-022 On leaving RUN, SHALL load dout_rd with the accumulator zero-extended to XLEN and go to DONE.
REQ-023 SHALL size the accumulator at 7 bits, so no overflow is possible (maximum value 64).
REQ-024 On accepting a SEXT or unused code, SHALL load dout_rd directly and go IDLE->DONE, so dout_valid rises the cycle after accept.
- SEXT.B: rs1[7] replicated into bits XLEN-1:8, rs1[7:0] kept.
- SEXT.H: rs1[15] replicated into bits XLEN-1:16, rs1[15:0] kept.
REQ-025 SHALL hold DONE, dout_valid and dout_rd stable while dout_ready=0.
REQ-026 On a DONE && dout_ready edge, SHALL return to IDLE; a new request is accepted one cycle later at the earliest (no same-cycle turnaround).
REQ-027 SHALL ignore din_valid outside IDLE and ignore dout_ready outside DONE.
REQ-028 Count-op latency: accept at edge k, k RUN cycles, dout_valid high from edge k+k_run, where 1 <= k_run <= N.

Reset
REQ-029 While reset=1, SHALL hold state at IDLE and drive dout_rd=0, dout_valid=0, din_ready=0, with the accumulator and idx cleared, independent of clock.
REQ-030 SHALL abort any in-flight operation when reset asserts in RUN or DONE; no result is emitted.
REQ-031 After reset deasserts, din_ready SHALL be 1 from the next rising clock edge.

Verification
REQ-032 XLEN=64, CHUNK=16, PCNT, rs1=0xFFFF_FFFF_FFFF_FFFF, insn3=0 -> 4 RUN cycles, then dout_rd=64.
REQ-033 CLZ, rs1=0x1 -> 4 RUN cycles (chunks 0-2 all ones), dout_rd=63. CTZ, rs1=0x100 -> 1 RUN cycle, dout_rd=8.
REQ-034 CLZW (insn3=1), rs1=0xFFFF_FFFF_0000_0000 -> 2 RUN cycles, dout_rd=32; upper half ignored.
REQ-035 SEXT.H, rs1=0x8000 -> dout_valid one cycle after accept, dout_rd=0xFFFF_FFFF_FFFF_8000.
REQ-036 Backpressure: hold dout_ready=0 for 5 cycles in DONE -> dout_valid=1, dout_rd unchanged and din_ready=0 throughout; extra din_valid pulses are ignored.
REQ-037 Assert reset mid-RUN of a PCNT -> all outputs go to 0 immediately; after release, a CTZ rs1=0x1 request returns 0 with no stale accumulator contribution.
